// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: walks pc through a synchronous-read memory and holds each word
// on `instruction` for HOLD_CYCLES clocks. Define IFU_STALL_EN to add the `stall` input.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned HOLD_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
`ifdef IFU_STALL_EN
    input  logic              stall,
`endif
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [3:0]      HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [3:0]          hold_q, hold_d;
    logic                en_q, en_d;
    logic                valid_q, valid_d;
    logic [31:0]         instr_q, instr_d;
    logic                stall_i;
    logic [ADDR_W:0]     len_in;
    logic [ADDR_W:0]     pc_plus1;

`ifdef IFU_STALL_EN
    assign stall_i = stall;
`else
    assign stall_i = 1'b0;
`endif

    assign len_in   = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    // compared one bit wider so a full-depth program ends at the last word instead of wrapping
    assign pc_plus1 = {1'b0, pc_q} + (ADDR_W + 1)'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        len_d   = len_q;
        hold_d  = hold_q;
        en_d    = 1'b0;
        valid_d = valid_q;
        instr_d = instr_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d = len_in;
                    pc_d  = '0;
                    if (len_in == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        en_d    = 1'b1;
                        addr_d  = '0;
                    end
                end
            end
            S_FETCH: begin
                if (stall_i) begin
                    en_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                instr_d = imem_rdata;
                valid_d = 1'b1;
                hold_d  = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!stall_i) begin
                    if (hold_q == HOLD_LAST) begin
                        instr_d = '0;
                        valid_d = 1'b0;
                        if (pc_plus1 == len_q) begin
                            state_d = S_DONE;
                        end else begin
                            pc_d    = pc_q + ADDR_W'(1);
                            addr_d  = pc_q + ADDR_W'(1);
                            en_d    = 1'b1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            hold_q  <= '0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            hold_q  <= hold_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
        end
    end

    assign imem_addr   = addr_q;
    assign imem_en     = en_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_ISSUE);
    assign done        = (state_q == S_DONE);

endmodule
